// File: rtl/rega_pkg.sv
// Shared definitions for the irrigation timer controller.
//   state_t            : controller states (IDLE, WATER, HOLD, COOL)
//   BCD_MAX            : largest legal BCD digit, used for clamping and wrap
//   COOL_TICKS_DEFAULT : default number of Tick pulses spent cooling down
//   clamp_bcd()        : limits a preset digit to the BCD range 0..9
package rega_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WATER = 2'd1,
    ST_HOLD  = 2'd2,
    ST_COOL  = 2'd3
  } state_t;

  localparam logic [3:0] BCD_MAX            = 4'd9;
  localparam int         COOL_TICKS_DEFAULT = 5;

  function automatic logic [3:0] clamp_bcd(input logic [3:0] d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// One BCD digit of a cascadable down counter.
//   clk, rst_n  : clock, asynchronous active-low reset
//   clear       : force the digit to 0 (highest priority)
//   load        : load load_val
//   en          : decrement request for the whole counter
//   borrow_in   : this digit steps only when a borrow arrives from below
//   digit       : registered digit value
//   borrow_out  : digit is 0 and a borrow is arriving, so the next digit steps
module bcd_down_digit
  import rega_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       en,
  input  logic       borrow_in,
  output logic [3:0] digit,
  output logic       borrow_out
);

  // Independent of en so the top can also use it as a "count is zero" flag.
  assign borrow_out = borrow_in && (digit == 4'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit <= 4'd0;
    end else if (clear) begin
      digit <= 4'd0;
    end else if (load) begin
      digit <= load_val;
    end else if (en && borrow_in) begin
      digit <= (digit == 4'd0) ? BCD_MAX : digit - 4'd1;
    end
  end

endmodule

// File: rtl/rega_timer_ctrl.sv
// Irrigation valve timer: waters for a BCD preset number of seconds, pauses
// while the reservoir is low, honours an operator abort, then cools down for
// COOL_TICKS seconds before another cycle may start.
//   Clk, Rst        : clock, asynchronous active-low reset
//   Tick            : one-Clk pulse per second
//   Dry, LowLvl     : soil-dry request, reservoir-low sensor
//   Abort           : operator stop (level)
//   PreT, PreU      : preset tens/units digits (BCD, clamped to 9)
//   Valve, Alarm    : valve drive, low-water hold indicator
//   Busy, Done      : not idle, one-cycle normal-completion pulse
//   DigT, DigU      : remaining time, BCD
// All outputs are flops; nothing combinational reaches a port.
module rega_timer_ctrl
  import rega_pkg::*;
#(
  parameter int COOL_TICKS = COOL_TICKS_DEFAULT
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       Tick,
  input  logic       Dry,
  input  logic       LowLvl,
  input  logic       Abort,
  input  logic [3:0] PreT,
  input  logic [3:0] PreU,
  output logic       Valve,
  output logic       Alarm,
  output logic       Busy,
  output logic       Done,
  output logic [3:0] DigT,
  output logic [3:0] DigU
);

  localparam logic [3:0] COOL_LAST = 4'(COOL_TICKS - 1);

  state_t     state, state_next;
  logic [3:0] cool_cnt, cool_cnt_next;
  logic       load, clear, dec, done_next;
  logic       units_borrow, tens_borrow;
  logic       start_ok, last_tick;

  // A 00 preset never starts a cycle; clamping cannot turn nonzero into zero.
  assign start_ok  = Dry && !LowLvl && !Abort && ((PreT | PreU) != 4'd0);
  assign last_tick = (DigT == 4'd0) && (DigU == 4'd1);

  bcd_down_digit u_units (
    .clk       (Clk),
    .rst_n     (Rst),
    .clear     (clear),
    .load      (load),
    .load_val  (clamp_bcd(PreU)),
    .en        (dec),
    .borrow_in (1'b1),
    .digit     (DigU),
    .borrow_out(units_borrow)
  );

  bcd_down_digit u_tens (
    .clk       (Clk),
    .rst_n     (Rst),
    .clear     (clear),
    .load      (load),
    .load_val  (clamp_bcd(PreT)),
    .en        (dec),
    .borrow_in (units_borrow),
    .digit     (DigT),
    .borrow_out(tens_borrow)
  );

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state    <= ST_IDLE;
      cool_cnt <= 4'd0;
      Valve    <= 1'b0;
      Alarm    <= 1'b0;
      Busy     <= 1'b0;
      Done     <= 1'b0;
    end else begin
      state    <= state_next;
      cool_cnt <= cool_cnt_next;
      Valve    <= (state_next == ST_WATER);
      Alarm    <= (state_next == ST_HOLD);
      Busy     <= (state_next != ST_IDLE);
      Done     <= done_next;
    end
  end

  // Priority inside WATER/HOLD: Abort, then LowLvl, then Tick.
  always_comb begin
    state_next    = state;
    cool_cnt_next = cool_cnt;
    load          = 1'b0;
    clear         = 1'b0;
    dec           = 1'b0;
    done_next     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start_ok) begin
          load       = 1'b1;
          state_next = ST_WATER;
        end
      end
      ST_WATER: begin
        if (Abort) begin
          clear         = 1'b1;
          cool_cnt_next = 4'd0;
          state_next    = ST_COOL;
        end else if (LowLvl) begin
          state_next = ST_HOLD;
        end else if (Tick) begin
          if (tens_borrow) begin
            // Count already 00 (unreachable from a legal load): leave
            // without wrapping to 99.
            cool_cnt_next = 4'd0;
            state_next    = ST_COOL;
          end else begin
            dec = 1'b1;
            if (last_tick) begin
              done_next     = 1'b1;
              cool_cnt_next = 4'd0;
              state_next    = ST_COOL;
            end
          end
        end
      end
      ST_HOLD: begin
        if (Abort) begin
          clear         = 1'b1;
          cool_cnt_next = 4'd0;
          state_next    = ST_COOL;
        end else if (!LowLvl) begin
          state_next = ST_WATER;
        end
      end
      ST_COOL: begin
        if (Tick) begin
          if (cool_cnt == COOL_LAST) begin
            cool_cnt_next = 4'd0;
            state_next    = ST_IDLE;
          end else begin
            cool_cnt_next = cool_cnt + 4'd1;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

endmodule
